// File: rtl/md5_pipe_ctrl.sv
// Sequencer for a 64-stage pipelined md5core. It feeds a batch of padded blocks,
// tracks which pipeline slots carry real messages, and finds the first digest equal to a target.
module md5_pipe_ctrl #(
  parameter int LATENCY = 64,
  parameter int IDX_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] num_msgs,
  input  logic [127:0]     target,
  input  logic             msg_valid,
  input  logic [511:0]     msg_data,
  output logic             msg_ready,
  output logic             core_en,
  output logic [511:0]     core_mesg,
  input  logic [31:0]      core_a,
  input  logic [31:0]      core_b,
  input  logic [31:0]      core_c,
  input  logic [31:0]      core_d,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [IDX_W-1:0] match_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   num_r;
  logic [IDX_W-1:0]   sent_r;
  logic [IDX_W-1:0]   recv_r;
  logic [IDX_W-1:0]   match_idx_r;
  logic [127:0]       target_r;
  logic [LATENCY-1:0] vld_r;
  logic               adv_d_r;
  logic               msg_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               match_r;

  logic               accept_s;
  logic               core_en_s;
  logic               event_s;
  logic               hit_s;
  logic [127:0]       digest_s;
  logic [511:0]       core_mesg_s;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Adds the MD5 IV back onto the raw chaining state and converts to canonical byte order.
  function automatic logic [127:0] finalise(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
    return {bswap32(32'h67452301 + a), bswap32(32'hefcdab89 + b),
            bswap32(32'h98badcfe + c), bswap32(32'h10325476 + d)};
  endfunction

  // Handshake, pipeline enable and result-event detection
  always_comb begin
    accept_s = msg_ready_r & msg_valid;
    if (accept_s) begin
      core_mesg_s = msg_data;
    end else begin
      core_mesg_s = 512'd0;
    end
    if (state_r == DRAIN) begin
      core_en_s = 1'b1;
    end else begin
      core_en_s = accept_s;
    end
    // adv_d gates the event so a frozen pipeline cannot report the same slot twice
    event_s  = vld_r[LATENCY-1] & adv_d_r;
    digest_s = finalise(core_a, core_b, core_c, core_d);
    hit_s    = event_s & (digest_s == target_r) & ~match_r;
  end

  assign core_en   = core_en_s;
  assign core_mesg = core_mesg_s;
  assign msg_ready = msg_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign match     = match_r;
  assign match_idx = match_idx_r;

  // Batch state machine, slot tracking and result bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      num_r       <= '0;
      sent_r      <= '0;
      recv_r      <= '0;
      match_idx_r <= '0;
      target_r    <= 128'd0;
      vld_r       <= '0;
      adv_d_r     <= 1'b0;
      msg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      adv_d_r <= core_en_s;
      if (core_en_s) begin
        vld_r <= {vld_r[LATENCY-2:0], accept_s};
      end
      if (event_s) begin
        recv_r <= recv_r + IDX_W'(1);
      end
      if (hit_s) begin
        match_r     <= 1'b1;
        match_idx_r <= recv_r;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            num_r       <= num_msgs;
            target_r    <= target;
            match_r     <= 1'b0;
            match_idx_r <= '0;
            sent_r      <= '0;
            recv_r      <= '0;
            if (num_msgs != '0) begin
              state_r     <= FEED;
              msg_ready_r <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (accept_s) begin
            sent_r <= sent_r + IDX_W'(1);
            if (sent_r == num_r - IDX_W'(1)) begin
              state_r     <= DRAIN;
              msg_ready_r <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (recv_r == num_r) begin
            state_r <= FIN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_pipe_ctrl.sv
// Bench for md5_pipe_ctrl: a queue-level md5core stand-in supplies raw chaining values,
// and each batch's expected first-match index is computed from the message list directly.
module tb_md5_pipe_ctrl;

  localparam int LAT = 64;
  localparam logic [127:0] ABC_MD5   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 32'h00000018, 32'd0};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
  localparam logic [511:0] X_BLK     = {32'h78800000, 416'd0, 32'h00000008, 32'd0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  num_msgs = 32'd0;
  logic [127:0] target = 128'd0;
  logic         msg_valid = 1'b0;
  logic [511:0] msg_data = 512'd0;
  logic         msg_ready, core_en, busy, done, match;
  logic [511:0] core_mesg;
  logic [31:0]  core_a, core_b, core_c, core_d;
  logic [31:0]  match_idx;

  int errors = 0;
  int checks = 0;

  md5_pipe_ctrl #(.LATENCY(LAT), .IDX_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_msgs(num_msgs), .target(target),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .core_en(core_en), .core_mesg(core_mesg),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .busy(busy), .done(done), .match(match), .match_idx(match_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Digest the stand-in core "computes" for a block: real MD5 for "abc", a keyed fold otherwise
  function automatic logic [127:0] ref_digest(input logic [511:0] m);
    if (m == ABC_BLK) return ABC_MD5;
    return m[127:0] ^ m[255:128] ^ m[383:256] ^ m[511:384] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] raw_of(input logic [511:0] m);
    logic [127:0] d;
    d = ref_digest(m);
    return {bsw(d[127:96]) - 32'h67452301, bsw(d[95:64]) - 32'hefcdab89,
            bsw(d[63:32]) - 32'h98badcfe, bsw(d[31:0]) - 32'h10325476};
  endfunction

  logic [511:0] pipe [LAT];

  // Stand-in md5core: LAT enable-gated stages, cleared by the shared reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 512'd0;
    end else if (core_en) begin
      pipe[0] <= core_mesg;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {core_a, core_b, core_c, core_d} = raw_of(pipe[LAT-1]);

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_batch(input string name, input int n, input logic [127:0] tgt,
                           input logic [511:0] msgs [$], input bit vpat [$],
                           input bit rnd, input bit poke);
    int exp_idx, idx, p, k, en_cnt, done_cnt, done_k, last_acc;
    bit v;
    exp_idx = -1;
    for (int i = 0; i < n; i++)
      if (exp_idx < 0 && ref_digest(msgs[i]) == tgt) exp_idx = i;
    idx = 0; p = 0; en_cnt = 0; done_cnt = 0; done_k = -1; last_acc = -1; k = 0;
    @(negedge clk);
    start = 1'b1; num_msgs = 32'(n); target = tgt; msg_valid = 1'b0;
    while (k < 4000 && (done_k < 0 || k < done_k + 4)) begin
      @(negedge clk);
      k++;
      start = poke && (k == 3);
      if (poke && k == 3) begin
        num_msgs = 32'd0; target = ~tgt;
      end else begin
        num_msgs = 32'(n); target = tgt;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      v = 1'b0;
      if (msg_ready && idx < n) begin
        if (p < vpat.size()) begin
          v = vpat[p]; p++;
        end else if (rnd) begin
          v = ($urandom_range(0, 2) != 0);
        end else begin
          v = 1'b1;
        end
      end
      msg_valid = v;
      msg_data  = v ? msgs[idx] : {16{$urandom}};
      #1;
      if (core_en) en_cnt++;
      if (msg_ready && !msg_valid) chk({name, " gap core_en"}, core_en, 0);
      if (msg_ready && msg_valid) begin
        chk({name, " core_mesg"}, core_mesg, msg_data);
        last_acc = k;
        idx++;
      end
    end
    msg_valid = 1'b0;
    start = 1'b0;
    chk({name, " done seen"}, done_k >= 0, 1);
    chk({name, " done pulses"}, done_cnt, 1);
    if (n > 0) begin
      chk({name, " done latency"}, done_k - last_acc, LAT + 2);
      chk({name, " core_en cycles"}, en_cnt, n + LAT + 1);
    end else begin
      chk({name, " done after start"}, done_k, 1);
      chk({name, " core_en cycles"}, en_cnt, 0);
    end
    chk({name, " match"}, match, exp_idx >= 0);
    chk({name, " match_idx"}, match_idx, (exp_idx >= 0) ? exp_idx : 0);
    chk({name, " busy idle"}, busy, 0);
  endtask

  initial begin
    logic [511:0] q [$];
    logic [511:0] tmsg;
    bit nov [$];
    bit gaps [$];
    int n;

    #2 reset = 1'b0;
    #20;
    chk("reset msg_ready", msg_ready, 0);
    chk("reset core_en", core_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset match", match, 0);
    chk("reset match_idx", match_idx, 0);
    chk("reset core_mesg", core_mesg, 0);
    @(negedge clk) reset = 1'b1;

    q = '{ABC_BLK};
    run_batch("single_abc", 1, ABC_MD5, q, nov, 1'b0, 1'b0);

    q = '{{16{$urandom}}, {16{$urandom}}, {16{$urandom}}};
    run_batch("no_match", 3, 128'd0, q, nov, 1'b0, 1'b1);

    q = '{EMPTY_BLK, ABC_BLK, X_BLK, ABC_BLK};
    run_batch("first_wins", 4, ABC_MD5, q, nov, 1'b0, 1'b0);

    q = '{X_BLK, EMPTY_BLK, ABC_BLK};
    gaps = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_batch("backpressure", 3, ABC_MD5, q, gaps, 1'b0, 1'b0);

    q.delete();
    run_batch("zero_msgs", 0, ABC_MD5, q, nov, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 8);
      tmsg = {16{$urandom}};
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 2) == 0) ? tmsg : {16{$urandom}});
      run_batch($sformatf("random%0d", r), n, ref_digest(tmsg), q, nov, 1'b1, r == 1);
    end

    // Abort a batch in the middle of feeding
    @(negedge clk);
    start = 1'b1; num_msgs = 32'd5; target = ABC_MD5;
    @(negedge clk);
    start = 1'b0; msg_valid = 1'b1; msg_data = ABC_BLK;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort msg_ready", msg_ready, 0);
    chk("abort busy", busy, 0);
    chk("abort core_en", core_en, 0);
    chk("abort match", match, 0);
    @(negedge clk);
    msg_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post-abort busy", busy, 0);
    chk("post-abort msg_ready", msg_ready, 0);
    chk("post-abort done", done, 0);

    q = '{X_BLK, ABC_BLK};
    run_batch("after_abort", 2, ABC_MD5, q, nov, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
